mux_scan_reg: RTL and testbench

//   Parametrised, registered N:1 multiplexer; next generation of the 4:1 mux.
//   Two modes: direct (external select) and scan (internal round-robin pointer

---
 rtl/mux_scan_reg_if.sv | 28 ++
 rtl/mux_scan_reg.sv | 107 ++++++++++
 tb/tb_mux_scan_reg.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_reg_if.sv
// Bundle of the mux_scan_reg data, select and handshake signals.
// The source side drives the inputs; the mux drives the registered outputs.
interface mux_scan_reg_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic [CHANNELS*WIDTH-1:0] din;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic [CHANNELS-1:0]       ch_en;
  logic                      in_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_ch;
  logic                      out_valid;
  logic                      out_ready;
  logic                      scan_wrap;

  modport master (
    output din, sel, mode, ch_en, in_valid, out_ready,
    input  out_data, out_ch, out_valid, scan_wrap
  );

  modport slave (
    input  din, sel, mode, ch_en, in_valid, out_ready,
    output out_data, out_ch, out_valid, scan_wrap
  );
endinterface

// File: rtl/mux_scan_reg.sv
// Registered N:1 multiplexer with direct select or round-robin scan of enabled
// channels, feeding a one-deep valid/ready output register.
module mux_scan_reg #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input logic           clk,
  input logic           rst,
  mux_scan_reg_if.slave bus
);

  if (CHANNELS < 2 || SEL_W != $clog2(CHANNELS)) begin : g_param_check
    $error("mux_scan_reg: need CHANNELS >= 2 and SEL_W == $clog2(CHANNELS)");
  end

  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_ch_q;
  logic             out_valid_q;
  logic             scan_wrap_q;
  logic [SEL_W-1:0] ptr_q;
  logic             last_mode_q;

  logic             accept;
  logic             can_cap;
  logic             capture;
  logic [SEL_W-1:0] start;
  logic [SEL_W-1:0] lo_c;
  logic [SEL_W-1:0] hi_c;
  logic             hi_hit;
  logic [SEL_W-1:0] scan_c;
  logic             scan_wrapped;
  logic [SEL_W-1:0] next_ptr;
  logic [SEL_W-1:0] cap_ch;
  logic [WIDTH-1:0] cap_data;

  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    accept  = out_valid_q & bus.out_ready;
    can_cap = ~out_valid_q | bus.out_ready;
    capture = bus.in_valid & can_cap & (~bus.mode | (|bus.ch_en));

    // Returning to scan after direct captures restarts the search at 0.
    start  = last_mode_q ? ptr_q : '0;
    lo_c   = '0;
    hi_c   = '0;
    hi_hit = 1'b0;
    // Descending walk: the last hit written is the lowest index, both for
    // the whole mask (lo) and for the part at or above the pointer (hi).
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (bus.ch_en[k]) begin
        lo_c = SEL_W'(k);
        if (k >= int'(start)) begin
          hi_c   = SEL_W'(k);
          hi_hit = 1'b1;
        end
      end
    end

    // No hit at or above the pointer means the search ran past the top.
    scan_c       = hi_hit ? hi_c : lo_c;
    scan_wrapped = ~hi_hit | (int'(hi_c) == CHANNELS - 1);
    next_ptr     = (int'(scan_c) == CHANNELS - 1) ? '0 : scan_c + SEL_W'(1);

    cap_ch   = bus.mode ? scan_c : bus.sel;
    cap_data = '0;
    // An out-of-range direct select matches no channel and captures zero.
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(cap_ch) == k) begin
        cap_data = bus.din[k*WIDTH +: WIDTH];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      scan_wrap_q <= 1'b0;
      ptr_q       <= '0;
      last_mode_q <= 1'b0;
    end else begin
      scan_wrap_q <= capture & bus.mode & scan_wrapped;
      if (capture) begin
        out_data_q  <= cap_data;
        out_ch_q    <= cap_ch;
        out_valid_q <= 1'b1;
        last_mode_q <= bus.mode;
        if (bus.mode) begin
          ptr_q <= next_ptr;
        end
      end else if (accept) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: a 4-channel and a 5-channel instance checked against
// an arithmetic reference model under directed and random stimulus.
module tb_mux_scan_reg;

  logic clk;
  logic rst;

  mux_scan_reg_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) bus4 ();
  mux_scan_reg_if #(.WIDTH(8), .CHANNELS(5), .SEL_W(3)) bus5 ();

  mux_scan_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  mux_scan_reg #(.WIDTH(8), .CHANNELS(5), .SEL_W(3)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int data;
    int ch;
    bit valid;
    bit wrap;
    int ptr;
    bit last_mode;
  } ref_t;

  ref_t m4, m5;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic ref_t ref_reset();
    ref_t r;
    r.data = 0; r.ch = 0; r.valid = 0; r.wrap = 0; r.ptr = 0; r.last_mode = 0;
    return r;
  endfunction

  // One clock edge of the behaviour, written from the channel-level rules.
  function automatic ref_t ref_step(input ref_t s, input int n, input logic [39:0] din,
                                    input int sel, input bit mode, input logic [4:0] en,
                                    input bit iv, input bit rdy);
    ref_t r;
    bit   go;
    int   start;
    int   c;
    r      = s;
    r.wrap = 0;
    go     = iv && (!s.valid || rdy) && (!mode || en != 0);
    if (s.valid && rdy) r.valid = 0;
    if (go) begin
      r.valid     = 1;
      r.last_mode = mode;
      if (!mode) begin
        r.ch   = sel;
        r.data = (sel < n) ? int'(din[sel*8 +: 8]) : 0;
      end else begin
        start = s.last_mode ? s.ptr : 0;
        c = -1;
        for (int d = 0; d < n && c < 0; d++) begin
          if (en[(start + d) % n]) c = (start + d) % n;
        end
        r.ch   = c;
        r.data = int'(din[c*8 +: 8]);
        r.ptr  = (c + 1) % n;
        r.wrap = (c < start) || (c == n - 1);
      end
    end
    return r;
  endfunction

  task automatic compare_all();
    check("d4.out_data",  32'(bus4.out_data),  32'(m4.valid || m4.data != 0 ? m4.data : 0));
    check("d4.out_ch",    32'(bus4.out_ch),    32'(m4.ch));
    check("d4.out_valid", 32'(bus4.out_valid), 32'(m4.valid));
    check("d4.scan_wrap", 32'(bus4.scan_wrap), 32'(m4.wrap));
    check("d5.out_data",  32'(bus5.out_data),  32'(m5.data));
    check("d5.out_ch",    32'(bus5.out_ch),    32'(m5.ch));
    check("d5.out_valid", 32'(bus5.out_valid), 32'(m5.valid));
    check("d5.scan_wrap", 32'(bus5.scan_wrap), 32'(m5.wrap));
  endtask

  // Inputs change only at the falling edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    m4 = ref_step(m4, 4, {8'h00, bus4.din}, int'(bus4.sel), bus4.mode,
                  {1'b0, bus4.ch_en}, bus4.in_valid, bus4.out_ready);
    m5 = ref_step(m5, 5, bus5.din, int'(bus5.sel), bus5.mode,
                  bus5.ch_en, bus5.in_valid, bus5.out_ready);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".d4.data"},  32'(bus4.out_data),  32'd0);
    check({tag, ".d4.ch"},    32'(bus4.out_ch),    32'd0);
    check({tag, ".d4.valid"}, 32'(bus4.out_valid), 32'd0);
    check({tag, ".d4.wrap"},  32'(bus4.scan_wrap), 32'd0);
    check({tag, ".d5.data"},  32'(bus5.out_data),  32'd0);
    check({tag, ".d5.ch"},    32'(bus5.out_ch),    32'd0);
    check({tag, ".d5.valid"}, 32'(bus5.out_valid), 32'd0);
    check({tag, ".d5.wrap"},  32'(bus5.scan_wrap), 32'd0);
  endtask

  initial begin
    int exp_ch [4];
    int exp_wr [4];

    rst = 1'b1;
    bus4.din = '0; bus4.sel = '0; bus4.mode = 1'b0; bus4.ch_en = '0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
    bus5.din = '0; bus5.sel = '0; bus5.mode = 1'b0; bus5.ch_en = '0;
    bus5.in_valid = 1'b0; bus5.out_ready = 1'b1;
    m4 = ref_reset();
    m5 = ref_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("idle_after_reset", 32'(bus4.out_valid), 32'd0);

    // Direct select of channel 2.
    bus4.din = 32'h44332211; bus4.sel = 2'd2; bus4.mode = 1'b0; bus4.in_valid = 1'b1;
    tick();
    check("direct.data",  32'(bus4.out_data),  32'h33);
    check("direct.ch",    32'(bus4.out_ch),    32'd2);
    check("direct.valid", 32'(bus4.out_valid), 32'd1);

    // Scan skips disabled channels: 1,3,1,3 with a wrap on every 3.
    exp_ch = '{1, 3, 1, 3};
    exp_wr = '{0, 1, 0, 1};
    bus4.mode = 1'b1; bus4.ch_en = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("scan_skip.ch",   32'(bus4.out_ch),    32'(exp_ch[i]));
      check("scan_skip.wrap", 32'(bus4.scan_wrap), 32'(exp_wr[i]));
    end

    // Scan to ptr=2, two direct captures, back to scan restarts at 0.
    bus4.ch_en = 4'b1111;
    tick();
    tick();
    check("mode_sw.pre", 32'(bus4.out_ch), 32'd1);
    bus4.mode = 1'b0; bus4.sel = 2'd0;
    tick();
    bus4.sel = 2'd3;
    tick();
    bus4.mode = 1'b1;
    tick();
    check("mode_sw.first_scan", 32'(bus4.out_ch), 32'd0);

    // Backpressure freezes the output and the pointer.
    tick();
    check("bp.before", 32'(bus4.out_ch), 32'd1);
    bus4.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus4.din = 32'($urandom);
      bus4.ch_en = 4'b0101;
      tick();
      check("bp.held_ch",    32'(bus4.out_ch),    32'd1);
      check("bp.held_valid", 32'(bus4.out_valid), 32'd1);
    end
    bus4.ch_en = 4'b1111;
    bus4.out_ready = 1'b1;
    tick();
    check("bp.release_ch", 32'(bus4.out_ch), 32'd2);

    // Scan with nothing enabled: accept drains, no new capture.
    bus4.ch_en = 4'b0000;
    tick();
    check("no_en.valid0", 32'(bus4.out_valid), 32'd0);
    tick();
    check("no_en.valid1", 32'(bus4.out_valid), 32'd0);
    check("no_en.ch",     32'(bus4.out_ch),    32'd2);
    bus4.in_valid = 1'b0;

    // Five channels: out-of-range direct select, then a scan wrap at 4.
    bus5.din = 40'hA5_B4_C3_D2_E1; bus5.mode = 1'b0; bus5.sel = 3'd6; bus5.in_valid = 1'b1;
    tick();
    check("oor.data",  32'(bus5.out_data),  32'd0);
    check("oor.ch",    32'(bus5.out_ch),    32'd6);
    check("oor.valid", 32'(bus5.out_valid), 32'd1);
    exp_ch = '{0, 4, 0, 4};
    exp_wr = '{0, 1, 0, 1};
    bus5.mode = 1'b1; bus5.ch_en = 5'b10001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("scan5.ch",   32'(bus5.out_ch),    32'(exp_ch[i]));
      check("scan5.wrap", 32'(bus5.scan_wrap), 32'(exp_wr[i]));
    end
    check("scan5.data", 32'(bus5.out_data), 32'hA5);

    // Random traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      bus4.din       = 32'($urandom);
      bus4.sel       = 2'($urandom_range(0, 3));
      bus4.mode      = 1'($urandom_range(0, 1));
      bus4.ch_en     = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      bus4.in_valid  = ($urandom_range(0, 3) != 0);
      bus4.out_ready = ($urandom_range(0, 9) < 7);
      bus5.din       = {8'($urandom), 32'($urandom)};
      bus5.sel       = 3'($urandom_range(0, 7));
      bus5.mode      = 1'($urandom_range(0, 1));
      bus5.ch_en     = ($urandom_range(0, 3) == 0) ? 5'b00000 : 5'($urandom);
      bus5.in_valid  = ($urandom_range(0, 3) != 0);
      bus5.out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    // Asynchronous reset in the middle of a cycle with a held sample.
    bus4.mode = 1'b0; bus4.sel = 2'd1; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    bus5.mode = 1'b0; bus5.sel = 3'd1; bus5.in_valid = 1'b1; bus5.out_ready = 1'b1;
    tick();
    check("pre_rst.valid4", 32'(bus4.out_valid), 32'd1);
    check("pre_rst.valid5", 32'(bus5.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    m4 = ref_reset();
    m5 = ref_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus4.in_valid = 1'b0;
    bus5.in_valid = 1'b0;
    tick();
    tick();
    check("post_rst.valid4", 32'(bus4.out_valid), 32'd0);
    bus4.in_valid = 1'b1;
    bus5.in_valid = 1'b1;
    tick();
    check("post_rst.capture4", 32'(bus4.out_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
